// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: five-cycle execute sequencer (IDLE/RD_A/RD_B/EXEC/WB) feeding a combinational ALU.
// Optional immediate operand B is compiled in when ALU_SEQ_IMM_EN is defined.
module alu_exec_sequencer #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 4,
  parameter int unsigned           OPER_WIDTH  = 4,
  parameter int unsigned           FLAGS_WIDTH = 2,
  parameter int unsigned           FLAG_C_POS  = 0,
  parameter int unsigned           FLAG_Z_POS  = 1,
  parameter logic [OPER_WIDTH-1:0] CMP_OPER    = OPER_WIDTH'(4'h4)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [OPER_WIDTH-1:0]  instr_oper,
  input  logic [ADDR_WIDTH-1:0]  instr_ra,
  input  logic [ADDR_WIDTH-1:0]  instr_rb,
  input  logic [ADDR_WIDTH-1:0]  instr_rd,
`ifdef ALU_SEQ_IMM_EN
  input  logic                   instr_use_imm,
  input  logic [DATA_WIDTH-1:0]  instr_imm,
`endif
  input  logic                   flags_load_en,
  input  logic [FLAGS_WIDTH-1:0] flags_load_data,
  output logic [ADDR_WIDTH-1:0]  rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]  rf_rd_data,
  output logic                   rf_wr_en,
  output logic [ADDR_WIDTH-1:0]  rf_wr_addr,
  output logic [DATA_WIDTH-1:0]  rf_wr_data,
  output logic [OPER_WIDTH-1:0]  alu_oper,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [FLAGS_WIDTH-1:0] alu_flags_in,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic [FLAGS_WIDTH-1:0] alu_flags_out,
  output logic [FLAGS_WIDTH-1:0] proc_flags,
  output logic                   done
);

  // Only the architected carry and zero bits are held in the flags register.
  localparam logic [FLAGS_WIDTH-1:0] FLAG_MASK =
    FLAGS_WIDTH'((1 << FLAG_C_POS) | (1 << FLAG_Z_POS));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t                  state;
  logic [OPER_WIDTH-1:0]   oper_q;
  logic [ADDR_WIDTH-1:0]   rb_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic                    accept;
`ifdef ALU_SEQ_IMM_EN
  logic                    use_imm_q;
  logic [DATA_WIDTH-1:0]   imm_q;
`endif

  assign accept       = instr_valid && instr_ready;
  assign alu_flags_in = proc_flags;

  // Operand B arrives from the read port in the EXEC cycle itself, so it cannot be registered.
`ifdef ALU_SEQ_IMM_EN
  assign alu_b = (state == EXEC) ? (use_imm_q ? imm_q : rf_rd_data) : '0;
`else
  assign alu_b = (state == EXEC) ? rf_rd_data : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      oper_q      <= '0;
      rb_q        <= '0;
      rd_q        <= '0;
      instr_ready <= 1'b1;
      rf_rd_addr  <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      alu_oper    <= '0;
      alu_a       <= '0;
      proc_flags  <= '0;
      done        <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // An external load in the accept cycle lands before this instruction executes.
          if (flags_load_en) begin
            proc_flags <= flags_load_data & FLAG_MASK;
          end
          if (accept) begin
            state       <= RD_A;
            instr_ready <= 1'b0;
            oper_q      <= instr_oper;
            rb_q        <= instr_rb;
            rd_q        <= instr_rd;
            rf_rd_addr  <= instr_ra;
`ifdef ALU_SEQ_IMM_EN
            use_imm_q   <= instr_use_imm;
            imm_q       <= instr_imm;
`endif
          end
        end
        RD_A: begin
          state      <= RD_B;
          rf_rd_addr <= rb_q;
        end
        RD_B: begin
          // R[ra] is on the read port now; alu_a doubles as the latched operand A.
          state      <= EXEC;
          rf_rd_addr <= '0;
          alu_a      <= rf_rd_data;
          alu_oper   <= oper_q;
        end
        EXEC: begin
          state      <= WB;
          alu_a      <= '0;
          alu_oper   <= '0;
          proc_flags <= alu_flags_out & FLAG_MASK;
          rf_wr_en   <= (alu_oper != CMP_OPER);
          rf_wr_addr <= rd_q;
          rf_wr_data <= alu_out;
          done       <= 1'b1;
        end
        WB: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          rf_wr_en    <= 1'b0;
          rf_wr_addr  <= '0;
          rf_wr_data  <= '0;
          done        <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          rf_rd_addr  <= '0;
          rf_wr_en    <= 1'b0;
          alu_a       <= '0;
          alu_oper    <= '0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: stub ALU and register file, directed plus random instructions.
// Define ALU_SEQ_IMM_EN to also exercise the immediate operand path.
`timescale 1ns/1ps
module tb_alu_exec_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                         OP_CMP = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7,
                         OP_LSL = 4'd8, OP_LSR = 4'd9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_oper = '0, instr_ra = '0, instr_rb = '0, instr_rd = '0;
`ifdef ALU_SEQ_IMM_EN
  logic        instr_use_imm = 1'b0;
  logic [15:0] instr_imm = '0;
`endif
  logic        flags_load_en = 1'b0;
  logic [1:0]  flags_load_data = '0;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [3:0]  alu_oper;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_flags_in, alu_flags_out, proc_flags;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf     [16];
  logic [15:0] exp_rf [16];
  logic [1:0]  exp_flags = '0;
  logic        tb_wr_en = 1'b0;
  logic [3:0]  tb_wr_addr = '0;
  logic [15:0] tb_wr_data = '0;

  always #5 clk = ~clk;

  alu_exec_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_oper(instr_oper), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
`ifdef ALU_SEQ_IMM_EN
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
`endif
    .flags_load_en(flags_load_en), .flags_load_data(flags_load_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .proc_flags(proc_flags), .done(done)
  );

  // ALU behaviour: returns {Z, C, result}; unknown opcodes pass A through and keep flags.
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [1:0] fl);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    c = fl[0];
    r = a;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
      OP_ADC: begin w = {1'b0, a} + {1'b0, b} + 17'(fl[0]); r = w[15:0]; c = w[16]; end
      OP_SUB, OP_CMP: begin r = a - b; c = (a >= b); end
      OP_SBC: begin
        r = a - b - 16'(!fl[0]);
        c = ({1'b0, a} >= ({1'b0, b} + 17'(!fl[0])));
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LSL: r = a << b[3:0];
      OP_LSR: r = a >> b[3:0];
      default: return {fl, a};
    endcase
    return {(r == 16'd0), c, r};
  endfunction

  assign {alu_flags_out, alu_out} = alu_fn(alu_oper, alu_a, alu_b, alu_flags_in);

  // Register file with one synchronous read port; the bench preloads through its own write port.
  always_ff @(posedge clk) begin
    rf_rd_data <= rf[rf_rd_addr];
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    if (tb_wr_en) rf[tb_wr_addr] <= tb_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] addr, input logic [15:0] data);
    tb_wr_en = 1'b1; tb_wr_addr = addr; tb_wr_data = data;
    tick();
    tb_wr_en = 1'b0;
    exp_rf[addr] = data;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rd,
                           input logic ld_en, input logic [1:0] ld_data, input logic noise,
                           input logic use_imm, input logic [15:0] imm);
    logic [15:0] a, b, er;
    logic [1:0]  ef;
    logic        seen, we;
    int          cyc, stray;
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr_oper = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
    flags_load_en = ld_en; flags_load_data = ld_data;
`ifdef ALU_SEQ_IMM_EN
    instr_use_imm = use_imm; instr_imm = imm;
`endif
    if (ld_en) exp_flags = ld_data;
    a = exp_rf[ra];
`ifdef ALU_SEQ_IMM_EN
    b = use_imm ? imm : exp_rf[rb];
`else
    b = exp_rf[rb];
    if (use_imm && imm == 16'hFFFF) b = exp_rf[rb];
`endif
    {ef, er} = alu_fn(op, a, b, exp_flags);
    we = (op != OP_CMP);
    tick();
    instr_valid = 1'b0;
    flags_load_en = noise;
    flags_load_data = ~exp_flags;
    cyc = 1; seen = 1'b0; stray = 0;
    while (cyc <= 8 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (rf_wr_en) stray++;
        tick();
        cyc++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " write edge"}, 32'(cyc), 32'd4);
    check({tag, " early write"}, 32'(stray), 32'd0);
    check({tag, " wr_en"}, 32'(rf_wr_en), 32'(we));
    if (we) begin
      check({tag, " wr_addr"}, 32'(rf_wr_addr), 32'(rd));
      check({tag, " wr_data"}, 32'(rf_wr_data), 32'(er));
    end
    check({tag, " flags"}, 32'(proc_flags), 32'(ef));
    check({tag, " flags_in"}, 32'(alu_flags_in), 32'(ef));
    tick();
    flags_load_en = 1'b0;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    if (we) exp_rf[rd] = er;
    exp_flags = ef;
    check({tag, " rf[rd]"}, 32'(rf[rd]), 32'(exp_rf[rd]));
  endtask

  initial begin
    int stray;
    // Reset state
    #12;
    check("rst wr_en", 32'(rf_wr_en), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst flags", 32'(proc_flags), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst alu_b", 32'(alu_b), 32'd0);
    check("rst alu_oper", 32'(alu_oper), 32'd0);
    check("rst rd_addr", 32'(rf_rd_addr), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check("rst ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

    // Directed cases
    preload(4'd1, 16'h0005); preload(4'd2, 16'h0003);
    run_instr("add", OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    check("add R3", 32'(rf[3]), 32'h0008);
    check("add flags", 32'(proc_flags), 32'd0);
    preload(4'd1, 16'h0003);
    run_instr("sub", OP_SUB, 4'd1, 4'd2, 4'd4, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
    check("sub R4", 32'(rf[4]), 32'h0000);
    check("sub flags", 32'(proc_flags), 32'd3);
    preload(4'd1, 16'h0002); preload(4'd2, 16'h0005);
    run_instr("cmp", OP_CMP, 4'd1, 4'd2, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    check("cmp flags", 32'(proc_flags), 32'd0);
    preload(4'd1, 16'hFFFF); preload(4'd2, 16'h0001); preload(4'd7, 16'h0000);
    run_instr("add_c", OP_ADD, 4'd1, 4'd2, 4'd6, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    check("add_c flags", 32'(proc_flags), 32'd3);
    run_instr("adc", OP_ADC, 4'd7, 4'd7, 4'd8, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    check("adc R8", 32'(rf[8]), 32'h0001);
    check("adc flags", 32'(proc_flags), 32'd0);
    run_instr("hazard_wr", OP_XOR, 4'd3, 4'd1, 4'd9, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    run_instr("hazard_rd", OP_ADD, 4'd9, 4'd9, 4'd10, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    run_instr("same_reg", OP_ADD, 4'd10, 4'd10, 4'd10, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    run_instr("unknown", 4'd13, 4'd3, 4'd4, 4'd12, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);

    // Reset during EXEC aborts the instruction
    preload(4'd1, 16'hFFFF);
    run_instr("pre_rst", OP_ADD, 4'd1, 4'd2, 4'd6, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    instr_valid = 1'b1; instr_oper = OP_ADD; instr_ra = 4'd2; instr_rb = 4'd2; instr_rd = 4'd11;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("abort flags", 32'(proc_flags), 32'd0);
    check("abort wr_en", 32'(rf_wr_en), 32'd0);
    check("abort done", 32'(done), 32'd0);
    exp_flags = '0;
    tick();
    reset_n = 1'b1;
    #1;
    check("abort ready", 32'(instr_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (rf_wr_en || done) stray++;
      tick();
    end
    check("abort no write", 32'(stray), 32'd0);
    check("abort R11", 32'(rf[11]), 32'(exp_rf[11]));

    // Flags load coinciding with accept
    preload(4'd1, 16'h0001);
    run_instr("ld_adc", OP_ADC, 4'd1, 4'd1, 4'd13, 1'b1, 2'b01, 1'b1, 1'b0, 16'd0);
    check("ld_adc R13", 32'(rf[13]), 32'h0003);
`ifdef ALU_SEQ_IMM_EN
    run_instr("imm_lsl", OP_LSL, 4'd1, 4'd2, 4'd14, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0004);
    check("imm_lsl R14", 32'(rf[14]), 32'h0010);
`endif

    // Random instruction stream
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 3) == 0) preload(4'($urandom), 16'($urandom));
      run_instr("rand", 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
                1'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 16; i++) check("final rf", 32'(rf[i]), 32'(exp_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
